// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream block family.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Output register occupancy states
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Channel-index width; at least one bit so a 2-channel mux still has a select
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_idx
);

    logic [2*CHANNELS-1:0] req_dbl;
    logic [CHANNELS-1:0]   req_rot;
    logic [SEL_W-1:0]      off;
    logic [SEL_W:0]        sum;

    // Rotate requests so bit 0 is the channel at ptr, then pick the lowest offset
    always_comb begin
        grant_valid = 1'b0;
        off         = '0;
        req_dbl     = {req, req} >> ptr;
        req_rot     = req_dbl[CHANNELS-1:0];
        for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_valid = 1'b1;
                off         = SEL_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SEL_W+1)'(CHANNELS)) begin
            sum = sum - (SEL_W+1)'(CHANNELS);
        end
        grant_idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-to-1 stream mux with fixed or round-robin selection and one output register stage.
module stream_mux_nx1
    import stream_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    input  logic                      out_ready
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             fix_valid;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Fixed-mode grant; a select beyond the channel count simply never matches
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                fix_valid = 1'b1;
            end
        end
    end

    // Grant mux, accept strobes and data select
    always_comb begin
        grant_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
        grant_idx   = (mode == MODE_RR) ? rr_idx   : sel;
        load_en     = (state_q == ST_EMPTY) || out_ready;
        xfer        = load_en && grant_valid;
        in_ready    = '0;
        sel_data    = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: reload on transfer (even while draining), empty on drain-only
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = ST_FULL;
            data_d  = sel_data;
            ch_d    = grant_idx;
            if (mode == MODE_RR) begin
                ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Scoreboard bench for stream_mux_nx1: a cycle reference model predicts accepts and beats.
module tb_stream_mux_nx1;

    localparam int C = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic [1:0]    sel;
    logic [3:0]    in_valid;
    logic [15:0]   in_data;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [3:0]    out_data;
    logic [1:0]    out_ch;
    logic          out_ready;

    int total = 0;
    int bad   = 0;

    logic [5:0] sb_q[$];
    bit         m_full = 1'b0;
    int         m_ptr  = 0;
    logic [3:0] m_data = '0;
    logic [1:0] m_ch   = '0;

    stream_mux_nx1 #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Which channel the rules say wins this cycle
    function automatic void ref_grant(input bit m, input int s, input logic [3:0] v,
                                      input int p, output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (!m) begin
            if (s < C && v[s]) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int k = 0; k < C; k++) begin
                int i;
                i = (p + k) % C;
                if (!gv && v[i]) begin
                    gv = 1'b1;
                    g  = i;
                end
            end
        end
    endfunction

    // Reference model: check current state and accepts, then advance across the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_data = '0;
            m_ch   = '0;
            sb_q.delete();
        end else begin
            bit         load;
            bit         gv;
            int         g;
            logic [3:0] exp_rdy;
            chk("out_valid", 32'(out_valid), 32'(m_full));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_ch", 32'(out_ch), 32'(m_ch));
            load = !m_full || out_ready;
            ref_grant(mode, int'(sel), in_valid, m_ptr, gv, g);
            exp_rdy = (load && gv) ? 4'(1 << g) : 4'b0000;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (load && gv) begin
                m_full = 1'b1;
                m_data = in_data[g*W +: W];
                m_ch   = 2'(g);
                sb_q.push_back({m_data, m_ch});
                if (mode) m_ptr = (g + 1) % C;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: every beat the consumer takes must be the oldest predicted beat
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [5:0] e;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected at %0t: got beat %0h ch %0d want none", $time, out_data, out_ch);
            end else begin
                e = sb_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e[5:2]));
                chk("sb_ch", 32'(out_ch), 32'(e[1:0]));
            end
        end
    end

    task automatic drv(input bit m, input logic [1:0] s, input logic [3:0] v,
                       input logic [15:0] d, input bit r);
        @(posedge clk);
        #1;
        mode      = m;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed select of channel 2
        drv(0, 2'd2, 4'b0100, 16'h0A00, 1);
        #1 chk("t1_in_ready", 32'(in_ready), 32'h4);
        drv(0, 2'd2, 4'b0000, 16'h0000, 1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA);
        chk("t1_ch", 32'(out_ch), 32'd2);

        // Round-robin across all four channels, one beat per cycle
        for (int k = 0; k < 6; k++) begin
            drv(1, 2'd0, 4'b1111, 16'h3210, 1);
            if (k > 0) chk("t2_seq", 32'(out_ch), 32'((k - 1) % C));
        end
        drv(1, 2'd0, 4'b0000, 16'h0000, 1);
        chk("t2_last", 32'(out_ch), 32'd1);

        // Backpressure holds the beat and blocks accepts
        drv(0, 2'd0, 4'b0001, 16'h0005, 1);
        for (int k = 0; k < 3; k++) begin
            drv(0, 2'd1, 4'b0010, 16'h0070, 0);
            #1;
            chk("t3_hold_data", 32'(out_data), 32'h5);
            chk("t3_hold_rdy", 32'(in_ready), 32'h0);
        end
        drv(0, 2'd1, 4'b0010, 16'h0070, 1);
        #1 chk("t3_release_rdy", 32'(in_ready), 32'h2);
        drv(0, 2'd1, 4'b0000, 16'h0000, 1);
        chk("t3_reload_valid", 32'(out_valid), 32'd1);
        chk("t3_reload_data", 32'(out_data), 32'h7);
        drv(0, 2'd0, 4'b0000, 16'h0000, 1);

        // Fixed select of an idle channel, then switch to round-robin
        drv(0, 2'd1, 4'b1000, 16'h9000, 1);
        drv(0, 2'd1, 4'b1000, 16'h9000, 1);
        chk("t4_no_xfer", 32'(out_valid), 32'd0);
        drv(1, 2'd1, 4'b1000, 16'h9000, 1);
        drv(1, 2'd1, 4'b0000, 16'h0000, 1);
        chk("t4_rr_ch", 32'(out_ch), 32'd3);

        // Rotating priority from ptr=1 with channels 0 and 2 requesting, then a drain
        drv(1, 2'd0, 4'b0001, 16'h0001, 1);
        drv(1, 2'd0, 4'b0101, 16'h0204, 1);
        drv(1, 2'd0, 4'b0101, 16'h0204, 1);
        chk("t5_first", 32'(out_ch), 32'd2);
        drv(1, 2'd0, 4'b0000, 16'h0000, 1);
        chk("t5_second", 32'(out_ch), 32'd0);
        drv(1, 2'd0, 4'b0000, 16'h0000, 1);
        chk("t5_drain_valid", 32'(out_valid), 32'd0);
        chk("t5_drain_data", 32'(out_data), 32'h4);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            drv(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 16'($urandom),
                ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while holding a stalled beat
        drv(0, 2'd3, 4'b1000, 16'h9000, 1);
        drv(0, 2'd3, 4'b1000, 16'h9000, 0);
        chk("t6_full", 32'(out_valid), 32'd1);
        chk("t6_full_data", 32'(out_data), 32'h9);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_ch", 32'(out_ch), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'b1111; in_data = 16'h3210; out_ready = 1'b1;
        drv(1, 2'd0, 4'b1111, 16'h3210, 1);
        chk("t6_restart_ch", 32'(out_ch), 32'd0);
        drv(1, 2'd0, 4'b1111, 16'h3210, 1);
        chk("t6_next_ch", 32'(out_ch), 32'd1);
        repeat (3) drv(0, 2'd0, 4'b0000, 16'h0000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
